id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32 core.
//   Latches decoded operands/controls from ID; drives EX_Rs1_o/EX_Rs2_o, consumed by the EX forwarding unit.
//   Inserts one-cycle bubbles on load-use hazards or flush. Freezes on a downstream memory hold.
// PARAMETERS
//   XLEN      32  datapath width (PC, operands, immediate)
//   FUNCT_W   10  width of packed {funct7,funct3} field
// PORTS
//   clk_i          in   1        clock, rising edge
//   rst_i          in   1        synchronous reset, active-high
//   ID_valid_i     in   1        ID holds a real instruction
//   ID_PC_i        in   XLEN     PC of ID instruction
//   ID_RS1data_i   in   XLEN     register-file read data, rs1
//   ID_RS2data_i   in   XLEN     register-file read data, rs2
//   ID_Imm_i       in   XLEN     sign-extended immediate
//   ID_Rs1_i       in   5        rs1 index
//   ID_Rs2_i       in   5        rs2 index
//   ID_Rd_i        in   5        rd index
//   ID_funct_i     in   FUNCT_W  {funct7,funct3}
//   ID_ctrl_i      in   8        {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,ALUOp[1:0]}
//   Flush_i        in   1        squash ID instruction (redirect)
//   MEM_Hold_i     in   1        downstream stall; freeze whole front end
//   WB_RegWrite_i  in   1        WB writes register file (bypass only)
//   WB_Rd_i        in   5        WB destination (bypass only)
//   WB_data_i      in   XLEN     WB write data (bypass only)
//   EX_valid_o     out  1        EX holds a real instruction
//   EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o  out XLEN  registered copies
//   EX_Rs1_o, EX_Rs2_o, EX_Rd_o  out 5    registered indices
//   EX_funct_o     out  FUNCT_W  registered funct
//   EX_ctrl_o      out  8        registered controls, same packing as ID_ctrl_i
//   Stall_o        out  1        load-use stall this cycle
//   PCWrite_o      out  1        PC may advance
//   IFIDWrite_o    out  1        IF/ID may load
// BEHAVIOUR
//   - Reset (rst_i=1 at edge): all EX_* outputs 0, EX_valid_o 0. Reset overrides all inputs, mid-stall too.
//   - hazard = EX_valid_o & EX_ctrl_o[MemRead] & (EX_Rd_o!=0) & ID_valid_i &
//     (EX_Rd_o==ID_Rs1_i | EX_Rd_o==ID_Rs2_i). Combinational.
//   - Stall_o = hazard & ~MEM_Hold_i; PCWrite_o = IFIDWrite_o = ~(hazard | MEM_Hold_i).
//   - Edge update, priority order:
//     1 MEM_Hold_i: all EX_* hold value (no bubble, no load).
//     2 Flush_i or hazard: bubble -> EX_ctrl_o=0, EX_valid_o=0, EX_Rd_o=0; other fields don't-care (load ID values).
//     3 else: load all ID_* fields; EX_valid_o=ID_valid_i; if ~ID_valid_i, EX_ctrl_o=0.
//   - Latency 1 cycle ID->EX. Load-use stall is exactly 1 cycle: bubble clears EX MemRead next cycle.
//   - Bubble never writes regfile or memory (RegWrite=MemWrite=MemRead=0).
//   - Flush_i with hazard: single bubble; Stall_o still asserts PC/IFID hold that cycle.
//   - x0: rd==0 never causes hazard; rs==0 with EX_Rd_o==0 never stalls.
// CONFIGURATION
//   IDEX_WB_BYPASS_EN defined: on load (case 3), if WB_RegWrite_i & WB_Rd_i!=0 & WB_Rd_i==ID_Rs1_i,
//     latch WB_data_i into EX_RS1data_o (same for rs2). Covers regfiles without write-first read.
//   Not defined: WB_* ports exist but ignored; operands latched from ID_RS*data_i only.
// TESTING
//   1 rst_i=1 two cycles with ID_valid_i=1 -> all EX_* 0, EX_valid_o 0, PCWrite_o=1.
//   2 lw x5 in EX (MemRead=1,Rd=5), ID add rs1=5 -> Stall_o=1, PCWrite_o=0; next edge EX_ctrl_o=0; following edge add loads, Stall_o=0.
//   3 lw x0 in EX, ID rs1=0 -> Stall_o=0, no bubble.
//   4 MEM_Hold_i=1 three cycles with EX_PC_o=0x100 -> EX_PC_o stays 0x100, Stall_o=0, PCWrite_o=0.
//   5 Flush_i=1, ID_ctrl_i=8'hC0 -> next EX_ctrl_o=0, EX_valid_o=0.
//   6 IDEX_WB_BYPASS_EN: WB Rd=7 data 0xDEAD_BEEF, ID rs2=7 RS2data=0 -> EX_RS2data_o=0xDEADBEEF; undefined -> 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and memory-hold freeze.
// Optional macro IDEX_WB_BYPASS_EN: capture same-cycle WB write data into the EX operands.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int FUNCT_W = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ID_valid_i,
    input  logic [XLEN-1:0]    ID_PC_i,
    input  logic [XLEN-1:0]    ID_RS1data_i,
    input  logic [XLEN-1:0]    ID_RS2data_i,
    input  logic [XLEN-1:0]    ID_Imm_i,
    input  logic [4:0]         ID_Rs1_i,
    input  logic [4:0]         ID_Rs2_i,
    input  logic [4:0]         ID_Rd_i,
    input  logic [FUNCT_W-1:0] ID_funct_i,
    input  logic [7:0]         ID_ctrl_i,
    input  logic               Flush_i,
    input  logic               MEM_Hold_i,
    input  logic               WB_RegWrite_i,
    input  logic [4:0]         WB_Rd_i,
    input  logic [XLEN-1:0]    WB_data_i,
    output logic               EX_valid_o,
    output logic [XLEN-1:0]    EX_PC_o,
    output logic [XLEN-1:0]    EX_RS1data_o,
    output logic [XLEN-1:0]    EX_RS2data_o,
    output logic [XLEN-1:0]    EX_Imm_o,
    output logic [4:0]         EX_Rs1_o,
    output logic [4:0]         EX_Rs2_o,
    output logic [4:0]         EX_Rd_o,
    output logic [FUNCT_W-1:0] EX_funct_o,
    output logic [7:0]         EX_ctrl_o,
    output logic               Stall_o,
    output logic               PCWrite_o,
    output logic               IFIDWrite_o
);

    // ctrl packing: {RegWrite,MemtoReg,MemRead,MemWrite,Branch,ALUSrc,ALUOp[1:0]}
    localparam int CTRL_MEMREAD = 5;

    logic            hazard;
    logic [XLEN-1:0] rs1_next;
    logic [XLEN-1:0] rs2_next;

    assign hazard = EX_valid_o & EX_ctrl_o[CTRL_MEMREAD] & (EX_Rd_o != 5'd0) & ID_valid_i &
                    ((EX_Rd_o == ID_Rs1_i) | (EX_Rd_o == ID_Rs2_i));

    assign Stall_o     = hazard & ~MEM_Hold_i;
    assign PCWrite_o   = ~(hazard | MEM_Hold_i);
    assign IFIDWrite_o = ~(hazard | MEM_Hold_i);

`ifdef IDEX_WB_BYPASS_EN
    // regfile without write-first read: take the value WB is writing this cycle
    logic rs1_bypass;
    logic rs2_bypass;
    assign rs1_bypass = WB_RegWrite_i & (WB_Rd_i != 5'd0) & (WB_Rd_i == ID_Rs1_i);
    assign rs2_bypass = WB_RegWrite_i & (WB_Rd_i != 5'd0) & (WB_Rd_i == ID_Rs2_i);
    assign rs1_next   = rs1_bypass ? WB_data_i : ID_RS1data_i;
    assign rs2_next   = rs2_bypass ? WB_data_i : ID_RS2data_i;
`else
    logic wb_unused;
    assign wb_unused = ^{WB_RegWrite_i, WB_Rd_i, WB_data_i};
    assign rs1_next  = ID_RS1data_i;
    assign rs2_next  = ID_RS2data_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            EX_valid_o   <= 1'b0;
            EX_PC_o      <= '0;
            EX_RS1data_o <= '0;
            EX_RS2data_o <= '0;
            EX_Imm_o     <= '0;
            EX_Rs1_o     <= '0;
            EX_Rs2_o     <= '0;
            EX_Rd_o      <= '0;
            EX_funct_o   <= '0;
            EX_ctrl_o    <= '0;
        end else if (!MEM_Hold_i) begin
            EX_PC_o      <= ID_PC_i;
            EX_RS1data_o <= rs1_next;
            EX_RS2data_o <= rs2_next;
            EX_Imm_o     <= ID_Imm_i;
            EX_Rs1_o     <= ID_Rs1_i;
            EX_Rs2_o     <= ID_Rs2_i;
            EX_funct_o   <= ID_funct_i;
            if (Flush_i || hazard) begin
                // bubble: nothing downstream may write regfile or memory
                EX_valid_o <= 1'b0;
                EX_ctrl_o  <= '0;
                EX_Rd_o    <= '0;
            end else begin
                EX_valid_o <= ID_valid_i;
                EX_ctrl_o  <= ID_valid_i ? ID_ctrl_i : 8'h00;
                EX_Rd_o    <= ID_Rd_i;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized self-checking bench for id_ex_stage against a transaction-level reference model.
// Build with or without IDEX_WB_BYPASS_EN to match the RTL build.
module tb_id_ex_stage;

    localparam int XLEN    = 32;
    localparam int FUNCT_W = 10;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               ID_valid_i;
    logic [XLEN-1:0]    ID_PC_i, ID_RS1data_i, ID_RS2data_i, ID_Imm_i;
    logic [4:0]         ID_Rs1_i, ID_Rs2_i, ID_Rd_i;
    logic [FUNCT_W-1:0] ID_funct_i;
    logic [7:0]         ID_ctrl_i;
    logic               Flush_i, MEM_Hold_i, WB_RegWrite_i;
    logic [4:0]         WB_Rd_i;
    logic [XLEN-1:0]    WB_data_i;
    logic               EX_valid_o;
    logic [XLEN-1:0]    EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o;
    logic [4:0]         EX_Rs1_o, EX_Rs2_o, EX_Rd_o;
    logic [FUNCT_W-1:0] EX_funct_o;
    logic [7:0]         EX_ctrl_o;
    logic               Stall_o, PCWrite_o, IFIDWrite_o;

    id_ex_stage #(.XLEN(XLEN), .FUNCT_W(FUNCT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ID_valid_i(ID_valid_i), .ID_PC_i(ID_PC_i),
        .ID_RS1data_i(ID_RS1data_i), .ID_RS2data_i(ID_RS2data_i), .ID_Imm_i(ID_Imm_i),
        .ID_Rs1_i(ID_Rs1_i), .ID_Rs2_i(ID_Rs2_i), .ID_Rd_i(ID_Rd_i), .ID_funct_i(ID_funct_i),
        .ID_ctrl_i(ID_ctrl_i), .Flush_i(Flush_i), .MEM_Hold_i(MEM_Hold_i),
        .WB_RegWrite_i(WB_RegWrite_i), .WB_Rd_i(WB_Rd_i), .WB_data_i(WB_data_i),
        .EX_valid_o(EX_valid_o), .EX_PC_o(EX_PC_o), .EX_RS1data_o(EX_RS1data_o),
        .EX_RS2data_o(EX_RS2data_o), .EX_Imm_o(EX_Imm_o), .EX_Rs1_o(EX_Rs1_o),
        .EX_Rs2_o(EX_Rs2_o), .EX_Rd_o(EX_Rd_o), .EX_funct_o(EX_funct_o), .EX_ctrl_o(EX_ctrl_o),
        .Stall_o(Stall_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the EX-stage instruction as an abstract record
    typedef struct {
        bit            valid;
        bit [31:0]     pc, rs1d, rs2d, imm;
        bit [4:0]      rs1, rs2, rd;
        bit [9:0]      funct;
        bit [7:0]      ctrl;
        bit            known;   // payload fields defined (not a bubble)
    } ex_rec_t;

    ex_rec_t m;
    bit      m_init = 0;
    logic    s_stall, s_pcw;

    function automatic bit model_hazard();
        bit is_load = m.valid && m.ctrl[5] && m.rd != 0;
        return is_load && ID_valid_i && (m.rd == ID_Rs1_i || m.rd == ID_Rs2_i);
    endfunction

    function automatic bit [31:0] operand(input bit [4:0] rs, input bit [31:0] rf_data);
        bit [31:0] v = rf_data;
`ifdef IDEX_WB_BYPASS_EN
        if (WB_RegWrite_i && WB_Rd_i != 0 && WB_Rd_i == rs) v = WB_data_i;
`endif
        return v;
    endfunction

    task automatic step();
        bit hz;
        @(negedge clk_i);
        #1;
        hz = model_hazard();
        s_stall = Stall_o;
        s_pcw   = PCWrite_o;
        if (m_init) begin
            chk("stall", {31'd0, Stall_o}, {31'd0, hz && !MEM_Hold_i});
            chk("pcwrite", {31'd0, PCWrite_o}, {31'd0, !(hz || MEM_Hold_i)});
            chk("ifidwrite", {31'd0, IFIDWrite_o}, {31'd0, !(hz || MEM_Hold_i)});
        end
        @(posedge clk_i);
        if (rst_i) begin
            m = '{default: 0};
            m.known = 1;
            m_init  = 1;
        end else if (!m_init || MEM_Hold_i) begin
            // frozen (or still unknown before first reset)
        end else if (Flush_i || hz) begin
            m.valid = 0; m.ctrl = 0; m.rd = 0; m.known = 0;
        end else begin
            m.valid = ID_valid_i;
            m.ctrl  = ID_valid_i ? ID_ctrl_i : 8'h00;
            m.rd    = ID_Rd_i;
            m.pc    = ID_PC_i;
            m.imm   = ID_Imm_i;
            m.rs1   = ID_Rs1_i;
            m.rs2   = ID_Rs2_i;
            m.funct = ID_funct_i;
            m.rs1d  = operand(ID_Rs1_i, ID_RS1data_i);
            m.rs2d  = operand(ID_Rs2_i, ID_RS2data_i);
            m.known = 1;
        end
        #1;
        if (m_init) begin
            chk("ex_valid", {31'd0, EX_valid_o}, {31'd0, m.valid});
            chk("ex_ctrl", {24'd0, EX_ctrl_o}, {24'd0, m.ctrl});
            chk("ex_rd", {27'd0, EX_Rd_o}, {27'd0, m.rd});
            if (m.known) begin
                chk("ex_pc", EX_PC_o, m.pc);
                chk("ex_rs1data", EX_RS1data_o, m.rs1d);
                chk("ex_rs2data", EX_RS2data_o, m.rs2d);
                chk("ex_imm", EX_Imm_o, m.imm);
                chk("ex_rs1", {27'd0, EX_Rs1_o}, {27'd0, m.rs1});
                chk("ex_rs2", {27'd0, EX_Rs2_o}, {27'd0, m.rs2});
                chk("ex_funct", {22'd0, EX_funct_o}, {22'd0, m.funct});
            end
        end
    endtask

    task automatic idle_inputs();
        rst_i = 0; ID_valid_i = 0; ID_PC_i = 0; ID_RS1data_i = 0; ID_RS2data_i = 0;
        ID_Imm_i = 0; ID_Rs1_i = 0; ID_Rs2_i = 0; ID_Rd_i = 0; ID_funct_i = 0; ID_ctrl_i = 0;
        Flush_i = 0; MEM_Hold_i = 0; WB_RegWrite_i = 0; WB_Rd_i = 0; WB_data_i = 0;
    endtask

    task automatic set_id(input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                          input bit [7:0] ctrl, input bit [31:0] pc);
        ID_valid_i = 1; ID_Rs1_i = rs1; ID_Rs2_i = rs2; ID_Rd_i = rd; ID_ctrl_i = ctrl;
        ID_PC_i = pc; ID_RS1data_i = $urandom; ID_RS2data_i = $urandom; ID_Imm_i = $urandom;
        ID_funct_i = 10'($urandom);
    endtask

    initial begin
        idle_inputs();
        // reset two cycles with a live ID instruction
        rst_i = 1;
        set_id(5'd3, 5'd4, 5'd5, 8'hE0, 32'h40);
        step();
        step();
        chk("rst_pcwrite", {31'd0, s_pcw}, 32'd1);
        chk("rst_ex_pc", EX_PC_o, 32'd0);
        rst_i = 0;

        // load-use: lw x5 then add rs1=x5
        set_id(5'd1, 5'd2, 5'd5, 8'hE0, 32'h80);
        step();
        set_id(5'd5, 5'd6, 5'd7, 8'h82, 32'h84);
        step();
        chk("lu_stall", {31'd0, s_stall}, 32'd1);
        chk("lu_pcwrite", {31'd0, s_pcw}, 32'd0);
        chk("lu_bubble_ctrl", {24'd0, EX_ctrl_o}, 32'd0);
        step();
        chk("lu_release", {31'd0, s_stall}, 32'd0);
        chk("lu_add_ctrl", {24'd0, EX_ctrl_o}, 32'h82);
        chk("lu_add_pc", EX_PC_o, 32'h84);

        // lw x0 followed by rs1=x0 must not stall
        set_id(5'd1, 5'd2, 5'd0, 8'hE0, 32'h90);
        step();
        set_id(5'd0, 5'd0, 5'd8, 8'h82, 32'h94);
        step();
        chk("x0_stall", {31'd0, s_stall}, 32'd0);
        chk("x0_ctrl", {24'd0, EX_ctrl_o}, 32'h82);

        // memory hold freezes EX at PC 0x100
        set_id(5'd1, 5'd2, 5'd3, 8'h80, 32'h100);
        step();
        set_id(5'd9, 5'd10, 5'd11, 8'hC0, 32'h200);
        MEM_Hold_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pc", EX_PC_o, 32'h100);
            chk("hold_stall", {31'd0, s_stall}, 32'd0);
            chk("hold_pcwrite", {31'd0, s_pcw}, 32'd0);
        end
        MEM_Hold_i = 0;

        // flush squashes a RegWrite/MemtoReg instruction
        set_id(5'd1, 5'd2, 5'd3, 8'hC0, 32'h300);
        Flush_i = 1;
        step();
        chk("flush_ctrl", {24'd0, EX_ctrl_o}, 32'd0);
        chk("flush_valid", {31'd0, EX_valid_o}, 32'd0);
        Flush_i = 0;

        // WB bypass into rs2
        set_id(5'd1, 5'd7, 5'd3, 8'h80, 32'h400);
        ID_RS2data_i = 32'h0;
        WB_RegWrite_i = 1; WB_Rd_i = 5'd7; WB_data_i = 32'hDEAD_BEEF;
`ifdef IDEX_WB_BYPASS_EN
        step();
        chk("wb_bypass_rs2", EX_RS2data_o, 32'hDEAD_BEEF);
`else
        step();
        chk("wb_ignored_rs2", EX_RS2data_o, 32'h0);
`endif
        WB_RegWrite_i = 0;

        // randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 2000; c++) begin
            rst_i         = ($urandom_range(0, 63) == 0);
            ID_valid_i    = ($urandom_range(0, 4) != 0);
            ID_PC_i       = $urandom;
            ID_RS1data_i  = $urandom;
            ID_RS2data_i  = $urandom;
            ID_Imm_i      = $urandom;
            ID_Rs1_i      = 5'($urandom_range(0, 7));
            ID_Rs2_i      = 5'($urandom_range(0, 7));
            ID_Rd_i       = 5'($urandom_range(0, 7));
            ID_funct_i    = 10'($urandom);
            ID_ctrl_i     = 8'($urandom);
            Flush_i       = ($urandom_range(0, 9) == 0);
            MEM_Hold_i    = ($urandom_range(0, 7) == 0);
            WB_RegWrite_i = 1'($urandom);
            WB_Rd_i       = 5'($urandom_range(0, 7));
            WB_data_i     = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
